// File: rtl/timer_seq_ctrl.sv
// Timer-mode sequencer for the PWM/timer main counter: one-shot/continuous runs, irq pulse + flag.
// Optional prescaler is enabled by defining TIMER_PRESCALE_EN (adds the i_psc_reg port).
module timer_seq_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 8
) (
  input  logic             i_chosen_clk,
  input  logic             i_rst,
  input  logic             i_core_en,
  input  logic             i_cont,
  input  logic             i_cnt_clr,
  input  logic             i_irq_clr,
  input  logic [CNT_W-1:0] i_period_reg,
`ifdef TIMER_PRESCALE_EN
  input  logic [PSC_W-1:0] i_psc_reg,
`endif
  output logic [CNT_W-1:0] o_counter,
  output logic [CNT_W-1:0] o_period_act,
  output logic             o_timer_en,
  output logic             o_irq,
  output logic             o_irq_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] r_period_act;
  logic             r_irq;
  logic             r_irq_flag;
  logic [PSC_W-1:0] r_psc;

  logic [PSC_W-1:0] w_psc_lim;
  logic             w_tick;
  logic             w_term;

  // Without the prescaler the limit is tied to 0, so every edge is a tick.
`ifdef TIMER_PRESCALE_EN
  assign w_psc_lim = i_psc_reg;
`else
  assign w_psc_lim = '0;
`endif

  assign w_tick = (r_psc == w_psc_lim);
  assign w_term = i_core_en && (r_state == S_RUN) && !i_cnt_clr && w_tick &&
                  (r_counter == r_period_act);

  always_ff @(posedge i_chosen_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_counter    <= '0;
      r_period_act <= '0;
      r_irq        <= 1'b0;
      r_irq_flag   <= 1'b0;
      r_psc        <= '0;
    end else begin
      r_irq <= w_term;
      // A terminal on the same edge as irq_clr keeps the flag set.
      if (w_term) begin
        r_irq_flag <= 1'b1;
      end else if (i_irq_clr) begin
        r_irq_flag <= 1'b0;
      end

      if (!i_core_en) begin
        r_state   <= S_IDLE;
        r_counter <= '0;
        r_psc     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_counter    <= '0;
            r_psc        <= '0;
            r_period_act <= i_period_reg;
            r_state      <= S_RUN;
          end
          S_RUN: begin
            if (i_cnt_clr) begin
              r_counter    <= '0;
              r_psc        <= '0;
              r_period_act <= i_period_reg;
            end else if (w_tick) begin
              r_psc <= '0;
              if (w_term) begin
                r_counter <= '0;
                if (i_cont) begin
                  r_period_act <= i_period_reg;
                end else begin
                  r_state <= S_DONE;
                end
              end else begin
                r_counter <= r_counter + CNT_W'(1);
              end
            end else begin
              r_psc <= r_psc + PSC_W'(1);
            end
          end
          S_DONE: begin
            r_counter <= '0;
            r_psc     <= '0;
            if (i_cnt_clr) begin
              r_period_act <= i_period_reg;
              r_state      <= S_RUN;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_psc     <= '0;
          end
        endcase
      end
    end
  end

  assign o_counter    = r_counter;
  assign o_period_act = r_period_act;
  assign o_timer_en   = (r_state == S_RUN);
  assign o_irq        = r_irq;
  assign o_irq_flag   = r_irq_flag;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: directed scenarios plus random traffic against an elapsed-edge model.
// Define TIMER_PRESCALE_EN to also exercise the prescaler.
module tb_timer_seq_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_core_en = 1'b0;
  logic        i_cont = 1'b0;
  logic        i_cnt_clr = 1'b0;
  logic        i_irq_clr = 1'b0;
  logic [15:0] i_period_reg = '0;
  logic [7:0]  i_psc_reg = '0;
  logic [15:0] o_counter;
  logic [15:0] o_period_act;
  logic        o_timer_en;
  logic        o_irq;
  logic        o_irq_flag;

  always #5 clk = ~clk;

  timer_seq_ctrl #(.CNT_W(16), .PSC_W(8)) u_dut (
    .i_chosen_clk (clk),
    .i_rst        (i_rst),
    .i_core_en    (i_core_en),
    .i_cont       (i_cont),
    .i_cnt_clr    (i_cnt_clr),
    .i_irq_clr    (i_irq_clr),
    .i_period_reg (i_period_reg),
`ifdef TIMER_PRESCALE_EN
    .i_psc_reg    (i_psc_reg),
`endif
    .o_counter    (o_counter),
    .o_period_act (o_period_act),
    .o_timer_en   (o_timer_en),
    .o_irq        (o_irq),
    .o_irq_flag   (o_irq_flag)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Drive values applied at the next step.
  bit          d_rst = 1'b1, d_en = 1'b0, d_cont = 1'b0, d_clr = 1'b0, d_iclr = 1'b0;
  logic [15:0] d_per = '0;
  logic [7:0]  d_psc = '0;

  // Model: mode 0 idle, 1 run, 2 done; m_pos counts raw edges elapsed in the interval.
  int m_mode = 0, m_pos = 0, m_per = 0;
  bit m_irq = 1'b0, m_flag = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int psc_div();
`ifdef TIMER_PRESCALE_EN
    return int'(i_psc_reg) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic int exp_counter();
    return (m_mode == 1) ? m_pos / psc_div() : 0;
  endfunction

  task automatic model_step();
    bit term = 1'b0;
    int len = (m_per + 1) * psc_div();
    if (i_rst) begin
      m_mode = 0; m_pos = 0; m_per = 0; m_irq = 1'b0; m_flag = 1'b0;
      return;
    end
    if (!i_core_en) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      m_per = int'(i_period_reg); m_mode = 1; m_pos = 0;
    end else if (m_mode == 1) begin
      if (i_cnt_clr) begin
        m_pos = 0; m_per = int'(i_period_reg);
      end else if (m_pos == len - 1) begin
        term = 1'b1; m_pos = 0;
        if (i_cont) m_per = int'(i_period_reg);
        else m_mode = 2;
      end else begin
        m_pos++;
      end
    end else if (i_cnt_clr) begin
      m_per = int'(i_period_reg); m_mode = 1; m_pos = 0;
    end
    m_irq = term;
    if (term) m_flag = 1'b1;
    else if (i_irq_clr) m_flag = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    i_rst = d_rst; i_core_en = d_en; i_cont = d_cont; i_cnt_clr = d_clr;
    i_irq_clr = d_iclr; i_period_reg = d_per; i_psc_reg = d_psc;
    @(posedge clk);
    model_step();
    #1;
    check_eq("counter", 32'(o_counter), 32'(exp_counter()));
    check_eq("period_act", 32'(o_period_act), 32'(m_per));
    check_eq("timer_en", 32'(o_timer_en), 32'(m_mode == 1));
    check_eq("irq", 32'(o_irq), 32'(m_irq));
    check_eq("irq_flag", 32'(o_irq_flag), 32'(m_flag));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model's counter reaches target in run mode; an expired budget is a failure.
  task automatic run_to_count(input int target, input string tag);
    int k = 0;
    while (!(m_mode == 1 && exp_counter() == target) && k < 200) begin
      step();
      k++;
    end
    check_eq(tag, 32'(k < 200), 32'd1);
  endtask

  task automatic restart(input logic [15:0] per, input bit cont);
    d_en = 1'b0; step();
    d_per = per; d_cont = cont; d_en = 1'b1;
  endtask

  initial begin
    // Reset, then continuous period 3.
    d_rst = 1'b1; steps(2);
    d_rst = 1'b0;
    check_eq("reset_counter", 32'(o_counter), 32'd0);
    check_eq("reset_flag", 32'(o_irq_flag), 32'd0);
    d_per = 16'd3; d_cont = 1'b1; d_en = 1'b1; steps(14);
    check_eq("cont_flag_set", 32'(o_irq_flag), 32'd1);

    // One-shot period 5, idle in done, then cnt_clr restart.
    restart(16'd5, 1'b0); steps(30);
    check_eq("oneshot_done_en", 32'(o_timer_en), 32'd0);
    d_clr = 1'b1; step(); d_clr = 1'b0; steps(10);

    // Shadow reload: period 7, switch to 2 mid-interval.
    restart(16'd7, 1'b1);
    run_to_count(3, "reach_cnt3");
    d_per = 16'd2; steps(20);
    check_eq("shadow_period", 32'(o_period_act), 32'd2);

    // irq_clr colliding with terminal, then alone.
    d_iclr = 1'b0;
    run_to_count(2, "reach_term");
    d_iclr = 1'b1; step();
    check_eq("collide_irq", 32'(o_irq), 32'd1);
    check_eq("collide_flag", 32'(o_irq_flag), 32'd1);
    step();
    check_eq("clear_flag", 32'(o_irq_flag), 32'd0);
    d_iclr = 1'b0;

    // Period 0 continuous: irq every edge.
    restart(16'd0, 1'b1); step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("p0_irq", 32'(o_irq), 32'd1);
    end

    // Disable at counter 4 keeps the flag; sync reset at counter 2 clears everything.
    restart(16'd9, 1'b1);
    run_to_count(4, "reach_cnt4");
    d_en = 1'b0; step();
    check_eq("dis_counter", 32'(o_counter), 32'd0);
    check_eq("dis_flag", 32'(o_irq_flag), 32'd1);
    d_en = 1'b1;
    run_to_count(2, "reach_cnt2");
    d_rst = 1'b1; step(); d_rst = 1'b0;
    check_eq("rst_flag", 32'(o_irq_flag), 32'd0);
    check_eq("rst_period", 32'(o_period_act), 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 2, period 1: counter moves every 3rd edge, irq every 6.
    d_en = 1'b0; d_psc = 8'd2; step();
    d_per = 16'd1; d_cont = 1'b1; d_en = 1'b1; steps(20);
    d_en = 1'b0; d_psc = 8'd0; step();
`endif

    // Random traffic; psc only changes while the block is held idle.
    for (int i = 0; i < 3000; i++) begin
      d_rst  = ($urandom % 64) == 0;
      d_en   = ($urandom % 24) != 0;
      if (($urandom % 40) == 0) d_cont = ~d_cont;
      d_clr  = ($urandom % 20) == 0;
      d_iclr = ($urandom % 8) == 0;
      if (($urandom % 10) == 0) d_per = 16'($urandom_range(0, 6));
`ifdef TIMER_PRESCALE_EN
      if ((!d_en || d_rst) && ($urandom % 4) == 0) d_psc = 8'($urandom_range(0, 3));
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Sequencing controller for the PWM/timer core's 16-bit main counter in timer mode. Owns the main counter and the active period shadow, and runs one-shot or continuous timing. Generates the one-cycle interrupt pulse and the sticky interrupt flag (ctrl[5]). Handles the counter-reset and interrupt-clear requests decoded from the Wishbone control register.

Parameters:
CNT_W, 16, width of main counter and period registers
PSC_W, 8, prescaler width (used only when TIMER_PRESCALE_EN is defined)

Ports:
chosen_clk  input  1  block clock (i_ext_clk or i_wb_clk, per ctrl[0])
rst  input  1  synchronous, active-high reset
core_en  input  1  ~ctrl[1] & ctrl[2]; timer mode and counter enable
cont  input  1  ctrl[3]; 1 = continuous, 0 = one-shot
cnt_clr  input  1  single-cycle request to restart the counter (ctrl[7] write)
irq_clr  input  1  single-cycle request to clear irq_flag
period_reg  input  CNT_W  programmed period from Wishbone register
counter  output  CNT_W  main counter value
period_act  output  CNT_W  period currently in use (shadow)
timer_en  output  1  high while state == RUN
irq  output  1  one-cycle interrupt pulse, routed to o_pwm
irq_flag  output  1  sticky interrupt flag, routed to ctrl[5]

Behaviour:
- All state is updated on posedge chosen_clk. When rst = 1 at an edge: state = IDLE, and counter, period_act, irq, irq_flag and timer_en are all 0.
- FSM states: IDLE(0), RUN(1), DONE(2). State is one-hot or binary; only the encoding values above are visible to the bench.
- IDLE:
  - counter = 0, irq = 0.
  - If core_en = 1: period_act <= period_reg, and go to RUN next edge.
- RUN:
  - counter increments by 1 per edge.
  - Terminal condition: counter == period_act at the edge.
  - On terminal: counter <= 0, irq <= 1 for one cycle, irq_flag <= 1.
  - After terminal with cont = 1: period_act <= period_reg (new period takes effect only at this boundary) and stay in RUN.
  - After terminal with cont = 0: go to DONE.
  - Period N gives N+1 edges per interval. Period 0 gives irq on every edge in continuous mode.
- DONE:
  - counter holds 0, irq = 0, timer_en = 0.
  - If cnt_clr = 1: period_act <= period_reg, go to RUN.
- core_en = 0 in any state: go to IDLE next edge, counter <= 0, irq <= 0. irq_flag is retained.
- cnt_clr in RUN: counter <= 0, period_act <= period_reg, no irq that edge even if terminal.
- Priority when events coincide: rst > core_en low > cnt_clr > terminal.
- irq_clr:
  - Clears irq_flag at the next edge.
  - If terminal occurs on the same edge, the set wins and irq_flag stays 1.
- Changes to cont take effect at the next terminal.
- Arithmetic:
  - counter is unsigned CNT_W bits.
  - Wrap past 2^CNT_W - 1 cannot occur because terminal is detected by equality and period_act ≤ max.
- period_reg is sampled only at IDLE→RUN, at cnt_clr and at continuous terminals, so mid-interval writes never glitch the current interval.

Optional Feature:
Macro TIMER_PRESCALE_EN.
- Defined:
  - Adds input port psc_reg [PSC_W-1:0] and an internal prescale counter.
  - In RUN, counter advances (and terminal is evaluated) only on edges where the prescale counter == psc_reg; the prescale counter then wraps to 0.
  - The prescale counter resets to 0 on rst, on leaving RUN, and on cnt_clr.
  - psc_reg = 0 behaves identically to the undefined case.
- Undefined: no psc_reg port, and counter advances every edge in RUN.

Test Plan:
- Continuous count: rst 2 cycles, period_reg=3, cont=1, core_en=1 → counter 0,1,2,3,0,…; irq pulses every 4th edge; irq_flag=1 after the first pulse.
- One-shot: period_reg=5, cont=0, core_en=1 → one irq 6 edges after entering RUN; state=DONE, counter=0, timer_en=0; no further irq for 20 cycles; cnt_clr pulse → restarts and fires again after 6 edges.
- Shadow reload: period_reg=7, cont=1, change period_reg to 2 at counter=3 → the current interval still ends at 7, and subsequent intervals are 3 edges.
- Clear collision: irq_clr asserted on the same edge as terminal → irq_flag stays 1; irq_clr alone on the next cycle → irq_flag=0.
- Disable/reset mid-run: core_en→0 at counter=4 → IDLE, counter=0, irq_flag retained; synchronous rst at counter=2 → all outputs 0 at that edge; period_reg=0, cont=1 → irq every edge.
- With TIMER_PRESCALE_EN and psc_reg=2, period_reg=1 → counter changes every 3rd edge; irq every 6 edges.
